// File: rtl/or4_stimulus_sequencer.sv
// Sweeps the four OR-gate inputs through 0000..1111, holding each pattern HOLD_CYCLES clocks,
// and samples the gate output e. Optional comparator enabled by OR4_SEQ_CHECK_EN.
module or4_stimulus_sequencer #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       e,
  output logic       busy,
  output logic       done,
  output logic [4:0] ones_cnt,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] p_q, p_d;
  logic [7:0] h_q, h_d;
  logic [4:0] ones_q, ones_d;
  logic       accept;
  logic       sample;

  assign accept = (state_q == StIdle) && start;
  // e is sampled on the last edge of each hold window
  assign sample = (state_q == StRun) && (h_q == HoldLast);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    h_d     = h_q;
    ones_d  = ones_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          p_d     = 4'b0000;
          h_d     = 8'd0;
          ones_d  = 5'd0;
        end
      end
      StRun: begin
        if (sample) begin
          if (e) ones_d = ones_q + 5'd1;
          h_d = 8'd0;
          if (p_q == 4'b1111) begin
            state_d = StDone;
          end else begin
            p_d = p_q + 4'd1;
          end
        end else begin
          h_d = h_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      p_q     <= 4'b0000;
      h_q     <= 8'd0;
      ones_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      h_q     <= h_d;
      ones_q  <= ones_d;
    end
  end

`ifdef OR4_SEQ_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (sample && (e != (|p_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign {a, b, c, d} = (state_q == StRun) ? p_q : 4'b0000;
  assign busy         = (state_q == StRun);
  assign done         = (state_q == StDone);
  assign ones_cnt     = ones_q;

endmodule
